// File: rtl/pulse_meas.sv
`default_nettype none
// ============================================================================
// Module      : pulse_meas
// Description : Synchronizes an asynchronous pulse into clk, measures its high
//               width in cycles and qualifies it against [MIN_WIDTH, MAX_WIDTH].
//               Legal pulse -> one-cycle stro + width; illegal pulse -> one-cycle
//               err + err_code (0 = too short, 1 = too long).
//               Optional feature macro: PULSE_MEAS_ERR_CNT_EN (saturating
//               8-bit error counter on err_cnt; tied to 0 when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_meas #(
    parameter int MIN_WIDTH   = 2,
    parameter int MAX_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    localparam int CNTW       = $clog2(MAX_WIDTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            pulsei,
    output logic            stro,
    output logic [CNTW-1:0] width,
    output logic            err,
    output logic            err_code,
    output logic            busy,
    output logic [7:0]      err_cnt
);

    localparam logic [CNTW-1:0] c_MAX = CNTW'(MAX_WIDTH);
    localparam logic [CNTW-1:0] c_MIN = CNTW'(MIN_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   sync_d_q;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic                   stro_q, stro_d;
    logic                   err_q, err_d;
    logic                   err_code_q, err_code_d;
    logic [CNTW-1:0]        width_q, width_d;
    logic                   busy_q;
    logic                   w_sync;
    logic                   w_rise;

    assign w_sync = sync_q[SYNC_STAGES-1];
    assign w_rise = w_sync & ~sync_d_q;

    // Synchronizer chain plus the delayed copy used for edge detection.
    // The chain resets to 0, so its output is meaningless until it has been
    // filled with real samples; fill_q tracks that, and sync_d is held at 1
    // until then so a level already high at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            fill_q   <= '0;
            sync_d_q <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pulsei};
            fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sync_d_q <= fill_q[SYNC_STAGES-1] ? w_sync : 1'b1;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            stro_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 1'b0;
            width_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stro_q     <= stro_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            width_q    <= width_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    // Next-state logic: measure while the synchronized level stays high.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stro_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        width_d    = width_q;
        case (state_q)
            S_IDLE: begin
                // ena only gates the start of a measurement
                if (w_rise && ena) begin
                    state_d = S_HIGH;
                    cnt_d   = CNTW'(1);
                end
            end
            S_HIGH: begin
                if (w_sync) begin
                    if (cnt_q == c_MAX) begin
                        err_d      = 1'b1;
                        err_code_d = 1'b1;
                        state_d    = S_OVER;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end else begin
                    if (cnt_q >= c_MIN) begin
                        stro_d  = 1'b1;
                        width_d = cnt_q;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 1'b0;
                    end
                    state_d = S_IDLE;
                end
            end
            S_OVER: begin
                // too-long pulse already reported; just wait for its end
                if (!w_sync) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef PULSE_MEAS_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating error counter, stepping together with the err output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign stro     = stro_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign width    = width_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_meas.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_meas
// Description : Directed bench for pulse_meas. Expected stro/err events are
//               queued when each pulse is driven and compared when the DUT
//               reports an event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_meas;

    localparam int N    = 2;
    localparam int MINW = 2;
    localparam int MAXW = 16;

    typedef struct {
        bit kind;   // 0 = stro, 1 = err
        int wid;    // width expected on the output at the event
        bit code;   // err_code when kind = 1
        int cyc;    // negedge index at which the event is visible
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       pulsei;
    logic       stro;
    logic [4:0] width;
    logic       err;
    logic       err_code;
    logic       busy;
    logic [7:0] err_cnt;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   last_w = 0;
    int   n_err  = 0;
    int   bz_lo  = 1;
    int   bz_hi  = 0;

    pulse_meas #(
        .MIN_WIDTH  (MINW),
        .MAX_WIDTH  (MAXW),
        .SYNC_STAGES(N)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .pulsei  (pulsei),
        .stro    (stro),
        .width   (width),
        .err     (err),
        .err_code(err_code),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Advance to the next negedge and check outputs against the scoreboard.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        check("busy", 32'(busy), 32'((cyc >= bz_lo) && (cyc <= bz_hi)));
        if (stro || err) begin
            if (q.size() == 0) begin
                check("unexpected_event", 32'({stro, err}), 32'd0);
            end else begin
                e = q.pop_front();
                check("event_cycle", 32'(cyc), 32'(e.cyc));
                check("event_kind", 32'({stro, err}), e.kind ? 32'd1 : 32'd2);
                check("width", 32'(width), 32'(e.wid));
                if (e.kind) check("err_code", 32'(err_code), 32'(e.code));
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            check("missed_event", 32'({stro, err}), e.kind ? 32'd1 : 32'd2);
        end
    endtask

    // Drive a pulse sampled high on w consecutive edges, queue its outcome.
    task automatic pulse(input int w, input bit en, input int drop_at = -1);
        int   k;
        exp_t e;
        k      = cyc + 1;
        ena    = en;
        pulsei = 1'b1;
        if (en) begin
            bz_lo = k + N;
            bz_hi = k + N + w - 1;
            if (w < MINW) begin
                e = '{kind: 1'b1, wid: last_w, code: 1'b0, cyc: k + w + N};
                n_err++;
            end else if (w <= MAXW) begin
                last_w = w;
                e = '{kind: 1'b0, wid: w, code: 1'b0, cyc: k + w + N};
            end else begin
                e = '{kind: 1'b1, wid: last_w, code: 1'b1, cyc: k + N + MAXW};
                n_err++;
            end
            q.push_back(e);
        end
        for (int i = 0; i < w; i++) begin
            tick();
            if (i == drop_at) ena = 1'b0;
        end
        pulsei = 1'b0;
        repeat (4) tick();
        ena = 1'b1;
    endtask

    task automatic check_errcnt();
`ifdef PULSE_MEAS_ERR_CNT_EN
        check("err_cnt", 32'(err_cnt), 32'((n_err > 255) ? 255 : n_err));
`else
        check("err_cnt", 32'(err_cnt), 32'(n_err * 0));
`endif
    endtask

    task automatic check_reset_outputs();
        check("rst_stro", 32'(stro), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_width", 32'(width), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        pulsei = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (4) tick();

        pulse(5, 1'b1);                 // legal, width 5
        check("width_held_5", 32'(width), 32'd5);
        pulse(1, 1'b1);                 // too short, width unchanged
        check("width_after_short", 32'(width), 32'd5);
        pulse(20, 1'b1);                // too long
        pulse(16, 1'b1);                // exactly MAX: legal
        pulse(17, 1'b1);                // MAX+1: too long
        pulse(2, 1'b1);                 // exactly MIN: legal
        check_errcnt();

        // level already high across reset release must not count
        rst_n  = 1'b0;
        pulsei = 1'b1;
        repeat (2) tick();
        check_reset_outputs();
        last_w = 0;
        n_err  = 0;
        rst_n  = 1'b1;
        repeat (10) tick();
        pulsei = 1'b0;
        repeat (4) tick();
        pulse(3, 1'b1);
        check("width_after_reset_high", 32'(width), 32'd3);

        pulse(4, 1'b0);                 // ena low at the edge: ignored
        check("width_after_ignored", 32'(width), 32'd3);
        pulse(4, 1'b1, 2);              // ena dropped inside HIGH
        check("width_after_ena_drop", 32'(width), 32'd4);
        check_errcnt();

`ifdef PULSE_MEAS_ERR_CNT_EN
        repeat (300) pulse(1, 1'b1);
        check_errcnt();
`endif

        repeat (5) tick();
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
